// File: rtl/pulser_io_core_if.sv
// Pin-side signal bundle for pulser_io_core: button, pulse channel and SPI byte port.
// Latency: none (wires only).
// Backpressure: none; SPI pacing is set by the external master's sck.
//
// Ports (modport slave = core view):
//   button            in   raw push-button level
//   db_state          out  debounced button level
//   delay/width       in   pulse delay / width in clk cycles (32 bit)
//   trigger_in        in   pulse start request
//   running/pulse_out out  channel busy / generated pulse
//   sck/mosi/ss       in   SPI mode-0 slave inputs (ss active-low)
//   txdata            in   byte for the next SPI slot
//   rxdata/rxready    out  last received byte / one-cycle update strobe
interface pulser_io_core_if;
  logic        button;
  logic        db_state;
  logic [31:0] delay;
  logic [31:0] width;
  logic        trigger_in;
  logic        running;
  logic        pulse_out;
  logic        sck;
  logic        mosi;
  logic        ss;
  logic [7:0]  txdata;
  logic [7:0]  rxdata;
  logic        rxready;

  // Board / controller side: drives the core inputs.
  modport master (
    output button, delay, width, trigger_in, sck, mosi, ss, txdata,
    input  db_state, running, pulse_out, rxdata, rxready
  );

  // Core side.
  modport slave (
    input  button, delay, width, trigger_in, sck, mosi, ss, txdata,
    output db_state, running, pulse_out, rxdata, rxready
  );
endinterface

// File: rtl/pulser_io_core.sv
// Delay-generator front end: button debouncer, one delay/width pulser, SPI mode-0 slave.
// Latency: debounce 2+DB_CYCLES clk; pulse edges exact to the cycle; SPI edges ~4 clk after sck.
// Backpressure: none; triggers while running are dropped, SPI timing is owned by the master.
//
// Ports:
//   clk   in   100 MHz system clock, rising edge
//   rst   in   asynchronous active-high reset
//   bus   slave modport of pulser_io_core_if (all functional signals except miso)
//   miso  out  SPI data out, high-impedance while ss is high
module pulser_io_core #(
  parameter int DB_CYCLES = 100000,
  parameter int DB_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  pulser_io_core_if.slave   bus,
  output wire               miso
);

  // ---------------------------------------------------------------- debounce
  logic [1:0]      btn_sync_q;
  logic            db_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync_q <= 2'b00;
      db_q       <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], bus.button};
      if (btn_sync_q[1] == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_q     <= btn_sync_q[1];
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign bus.db_state = db_q;

  // ------------------------------------------------------------ pulse channel
  typedef enum logic [1:0] {P_IDLE, P_DELAY, P_PULSE} pstate_t;

  pstate_t     state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] width_q, width_d;
  logic        running_q, running_d;
  logic        pulse_q, pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= P_IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      running_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      running_q <= running_d;
      pulse_q   <= pulse_d;
    end
  end

  // cnt_q holds the cycles remaining in the current phase minus one, so the
  // phase ends on the edge where it reads zero; no delay+width sum is formed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    running_d = running_q;
    pulse_d   = pulse_q;
    case (state_q)
      P_IDLE: begin
        if (bus.trigger_in) begin
          running_d = 1'b1;
          width_d   = bus.width;
          if (bus.delay == 32'd0 && bus.width != 32'd0) begin
            pulse_d = 1'b1;
            cnt_d   = bus.width - 32'd1;
            state_d = P_PULSE;
          end else begin
            // delay=0,width=0 still holds running for one cycle.
            cnt_d   = (bus.delay == 32'd0) ? 32'd0 : bus.delay - 32'd1;
            state_d = P_DELAY;
          end
        end
      end
      P_DELAY: begin
        if (cnt_q == 32'd0) begin
          if (width_q == 32'd0) begin
            running_d = 1'b0;
            state_d   = P_IDLE;
          end else begin
            pulse_d = 1'b1;
            cnt_d   = width_q - 32'd1;
            state_d = P_PULSE;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      P_PULSE: begin
        if (cnt_q == 32'd0) begin
          pulse_d   = 1'b0;
          running_d = 1'b0;
          state_d   = P_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  assign bus.running   = running_q;
  assign bus.pulse_out = pulse_q;

  // ---------------------------------------------------------------- SPI slave
  logic [2:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic       sck_prev_q, ss_prev_q;
  logic [7:0] rx_sh_q, tx_sh_q, rxdata_q;
  logic [2:0] bit_cnt_q;
  logic       rxready_q;

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_fall;

  assign sck_s    = sck_sync_q[2];
  assign ss_s     = ss_sync_q[2];
  assign mosi_s   = mosi_sync_q[2];
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign ss_fall  = ~ss_s  &  ss_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 3'b000;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rxdata_q    <= '0;
      bit_cnt_q   <= '0;
      rxready_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], bus.sck};
      ss_sync_q   <= {ss_sync_q[1:0], bus.ss};
      mosi_sync_q <= {mosi_sync_q[1:0], bus.mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      rxready_q   <= 1'b0;

      if (ss_s) begin
        bit_cnt_q <= '0;
      end else if (ss_fall) begin
        tx_sh_q   <= bus.txdata;
        bit_cnt_q <= '0;
      end else begin
        if (sck_rise) begin
          rx_sh_q   <= {rx_sh_q[6:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rxdata_q  <= {rx_sh_q[6:0], mosi_s};
            rxready_q <= 1'b1;
          end
        end
        // Reload the cycle after the strobe so the decoder can answer rxready
        // with a new txdata. bit_cnt_q==0 marks the fall after the 8th bit,
        // which must not shift the freshly reloaded byte.
        if (rxready_q) begin
          tx_sh_q <= bus.txdata;
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
          tx_sh_q <= {tx_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.rxdata  = rxdata_q;
  assign bus.rxready = rxready_q;
  assign miso        = ss_s ? 1'bz : tx_sh_q[7];

endmodule

// File: tb/tb_pulser_io_core.sv
module tb_pulser_io_core;

  localparam int HALF = 5;  // SPI half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  miso;

  int vectors     = 0;
  int miscompares = 0;

  pulser_io_core_if bus();

  // Undriven miso reads as 1, which is how the high-impedance state is seen.
  pullup (miso);

  pulser_io_core #(.DB_CYCLES(8), .DB_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .miso (miso)
  );

  always #5 clk = ~clk;

  logic [7:0] frame [6] = '{8'h10, 8'h03, 8'h00, 8'h00, 8'h01, 8'hF4};

  // rxready collector
  logic [7:0] rx_q [$];
  int         rx_long = 0;
  logic       rx_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.rxready) begin
      rx_q.push_back(bus.rxdata);
      if (rx_prev) rx_long++;
    end
    rx_prev = bus.rxready;
  end

  task automatic test_reset();
    #1;
    vectors++;
    if (bus.db_state !== 1'b0 || bus.running !== 1'b0 || bus.pulse_out !== 1'b0 ||
        bus.rxdata !== 8'h00 || bus.rxready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: db=%b run=%b pulse=%b rxdata=%h rxready=%b, want all 0",
               bus.db_state, bus.running, bus.pulse_out, bus.rxdata, bus.rxready);
    end
    vectors++;
    if (miso !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_miso_z: miso=%b, want released (pulled 1)", miso);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_debounce();
    // 5-cycle glitch must not pass
    bus.button = 1'b1;
    repeat (5) @(negedge clk);
    bus.button = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.db_state !== 1'b0) begin
        miscompares++;
        $display("FAIL debounce_glitch: cycle %0d db_state=%b, want 0", i, bus.db_state);
      end
    end
    // Stable press: db_state rises on the 10th edge (2 sync + 8 count)
    bus.button = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.db_state !== (i >= 10)) begin
        miscompares++;
        $display("FAIL debounce_press: edge %0d db_state=%b, want %b", i, bus.db_state, i >= 10);
      end
    end
    bus.button = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.db_state !== (i < 10)) begin
        miscompares++;
        $display("FAIL debounce_release: edge %0d db_state=%b, want %b", i, bus.db_state, i < 10);
      end
    end
  endtask

  // One-cycle trigger; sample i is taken after the i-th edge following the accept edge.
  task automatic run_pulse(input int d, input int w);
    int len;
    logic exp_run, exp_pulse;
    len = (w == 0) ? ((d == 0) ? 1 : d) : d + w;
    bus.delay      = 32'(d);
    bus.width      = 32'(w);
    bus.trigger_in = 1'b1;
    @(negedge clk);
    bus.trigger_in = 1'b0;
    for (int i = 0; i < len + 4; i++) begin
      if (i == 1) begin
        // changes mid-pulse must not affect this pulse
        bus.delay = 32'd7;
        bus.width = 32'd9;
      end
      exp_run   = (i < len);
      exp_pulse = (w != 0) && (i >= d) && (i < d + w);
      vectors++;
      if (bus.running !== exp_run || bus.pulse_out !== exp_pulse) begin
        miscompares++;
        $display("FAIL pulse_d%0d_w%0d: cycle %0d run=%b pulse=%b, want run=%b pulse=%b",
                 d, w, i, bus.running, bus.pulse_out, exp_run, exp_pulse);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pulse();
    run_pulse(100, 100);
    run_pulse(0, 3);
    run_pulse(5, 0);
    run_pulse(0, 0);
    run_pulse(1, 1);
  endtask

  task automatic test_retrigger();
    // Held trigger: 20 busy cycles, one idle cycle, then re-accept -> period 21.
    int   ph;
    logic exp_run, exp_pulse;
    bus.delay      = 32'd10;
    bus.width      = 32'd10;
    bus.trigger_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      ph        = i % 21;
      exp_run   = (ph < 20);
      exp_pulse = (ph >= 10) && (ph < 20);
      vectors++;
      if (bus.running !== exp_run || bus.pulse_out !== exp_pulse) begin
        miscompares++;
        $display("FAIL retrigger: cycle %0d run=%b pulse=%b, want run=%b pulse=%b",
                 i, bus.running, bus.pulse_out, exp_run, exp_pulse);
      end
      @(negedge clk);
    end
    bus.trigger_in = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    bus.delay      = 32'd0;
    bus.width      = 32'd50;
    bus.trigger_in = 1'b1;
    @(negedge clk);
    bus.trigger_in = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (bus.running !== 1'b1 || bus.pulse_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pulse_active: run=%b pulse=%b, want 1 1", bus.running, bus.pulse_out);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.running !== 1'b0 || bus.pulse_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: run=%b pulse=%b, want 0 0", bus.running, bus.pulse_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    vectors++;
    if (bus.running !== 1'b0 || bus.pulse_out !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_idle: run=%b pulse=%b, want 0 0", bus.running, bus.pulse_out);
    end
  endtask

  // Mode-0 master: n bits MSB first; miso sampled just before each rising sck.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] got);
    logic [7:0] tmp;
    tmp = 8'h00;
    for (int b = 7; b > 7 - n; b--) begin
      bus.mosi = tx[b];
      repeat (HALF) @(negedge clk);
      tmp[b] = miso;
      bus.sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b0;
    end
    got = tmp;
  endtask

  task automatic test_spi_frame();
    logic [7:0] got;
    logic [7:0] want;
    rx_q.delete();
    rx_long      = 0;
    bus.txdata   = 8'hA5;
    bus.ss       = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    bus.txdata   = 8'h3C;
    for (int k = 0; k < 6; k++) begin
      spi_bits(frame[k], 8, got);
      want = (k == 0) ? 8'hA5 : 8'h3C;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL spi_miso_byte%0d: got %h, want %h", k, got, want);
      end
    end
    repeat (HALF) @(negedge clk);
    bus.ss = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (rx_q.size() != 6) begin
      miscompares++;
      $display("FAIL spi_rx_count: got %0d strobes, want 6", rx_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (rx_q[k] !== frame[k]) begin
          miscompares++;
          $display("FAIL spi_rxdata%0d: got %h, want %h", k, rx_q[k], frame[k]);
        end
      end
    end
    vectors++;
    if (rx_long != 0) begin
      miscompares++;
      $display("FAIL spi_rxready_width: %0d multi-cycle strobes, want 0", rx_long);
    end
    vectors++;
    if (miso !== 1'b1) begin
      miscompares++;
      $display("FAIL spi_miso_z_after_frame: miso=%b, want released (pulled 1)", miso);
    end
  endtask

  task automatic test_spi_abort();
    logic [7:0] got;
    rx_q.delete();
    bus.txdata = 8'h00;
    bus.ss     = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    spi_bits(8'hF0, 4, got);
    vectors++;
    if (got[7:4] !== 4'h0) begin
      miscompares++;
      $display("FAIL spi_abort_miso_driven: got %h, want 0", got[7:4]);
    end
    repeat (HALF) @(negedge clk);
    bus.ss = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (rx_q.size() != 0) begin
      miscompares++;
      $display("FAIL spi_abort_no_rxready: got %0d strobes, want 0", rx_q.size());
    end
    vectors++;
    if (miso !== 1'b1) begin
      miscompares++;
      $display("FAIL spi_abort_miso_z: miso=%b, want released (pulled 1)", miso);
    end
    // Next frame must be clean
    bus.txdata = 8'h5A;
    bus.ss     = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    spi_bits(8'hC3, 8, got);
    vectors++;
    if (got !== 8'h5A) begin
      miscompares++;
      $display("FAIL spi_next_miso: got %h, want 5a", got);
    end
    repeat (HALF) @(negedge clk);
    bus.ss = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (rx_q.size() != 1) begin
      miscompares++;
      $display("FAIL spi_next_count: got %0d strobes, want 1", rx_q.size());
    end else begin
      vectors++;
      if (rx_q[0] !== 8'hC3) begin
        miscompares++;
        $display("FAIL spi_next_rxdata: got %h, want c3", rx_q[0]);
      end
    end
    vectors++;
    if (miso !== 1'b1) begin
      miscompares++;
      $display("FAIL spi_next_miso_z: miso=%b, want released (pulled 1)", miso);
    end
  endtask

  initial begin
    bus.button     = 1'b0;
    bus.delay      = 32'd0;
    bus.width      = 32'd0;
    bus.trigger_in = 1'b0;
    bus.sck        = 1'b0;
    bus.mosi       = 1'b0;
    bus.ss         = 1'b1;
    bus.txdata     = 8'h00;
    @(negedge clk);
    test_reset();
    test_debounce();
    test_pulse();
    test_retrigger();
    test_reset_mid_pulse();
    test_spi_frame();
    test_spi_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulser_io_core.md
Name: pulser_io_core

Overview:
- Front-end and timing primitives of the digital delay generator, packaged as one block.
- Contains three independent sub-functions:
  - a push-button debouncer;
  - a delay/width pulse counter (one pulser channel);
  - an SPI slave byte engine that links the controller MCU to the command decoder.
- Sits between the board pins and the command/multiplexing logic; 100 MHz clock (10 ns resolution).

Parameters:
- DB_CYCLES, 100000: clk cycles the synchronized button must be stable before db_state follows it (1 ms at 100 MHz).
- DB_W, 17: width of the debounce counter; must hold DB_CYCLES.

Ports:
- clk  input  1  system clock, 100 MHz, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- button  input  1  raw push-button, asynchronous.
- db_state  output  1  debounced button level.
- delay  input  32  pulse delay in clk cycles.
- width  input  32  pulse width in clk cycles.
- trigger_in  input  1  start request, sampled each clk.
- running  output  1  channel busy (delay or pulse in progress).
- pulse_out  output  1  generated pulse.
- sck  input  1  SPI clock from master, asynchronous.
- mosi  input  1  SPI data in.
- miso  output  1  SPI data out.
- ss  input  1  SPI slave select, active-low.
- txdata  input  8  byte to send in the next SPI byte slot.
- rxdata  output  8  last fully received byte.
- rxready  output  1  one-cycle strobe when rxdata is updated.

Behaviour:

Reset (rst=1) forces:
- db_state=0, debounce counter 0, synchronizers 0.
- running=0, pulse_out=0, counters 0.
- rxdata=0, rxready=0, bit count 0, SPI synchronizers to idle (sck=0, ss=1).
- Reset mid-pulse aborts the pulse immediately.

Debounce:
- button passes through a 2-FF synchronizer.
- If the synchronized value equals db_state, the counter clears.
- Otherwise the counter increments; when it reaches DB_CYCLES-1, db_state takes the synchronized value and the counter clears.
- Any glitch shorter than DB_CYCLES cycles never reaches db_state.

Pulse counter:
- Idle edge with trigger_in=1: latch delay and width, set running=1.
- pulse_out rises exactly delay cycles after running rises; delay=0 means it rises on the same edge.
- pulse_out stays high exactly width cycles. running and pulse_out fall on the same edge.
- width=0: no pulse; running lasts delay cycles, minimum 1 cycle.
- trigger_in while running is ignored; no retrigger or queueing.
- delay/width changes while running take effect on the next trigger.
- Counters are 32-bit. Maximum delay+width ≈ 86 s, with no wrap inside a pulse.

SPI slave (mode 0: CPOL=0, CPHA=0, MSB first):
- sck, ss and mosi pass through a 3-FF synchronizer; edges are detected on the synchronized sck.
- Requirement on the master: sck high and low phases ≥ 4 clk cycles each.
- ss high: bit count cleared, no rxready; miso high-impedance.
- ss falling edge: txdata loaded into the tx shift register, and its MSB is driven on miso.
- Synchronized sck rising edge with ss low: mosi shifted into the rx register.
- After the 8th rising edge: rxdata updated, and rxready high for exactly 1 clk.
- One clk after the rxready pulse: txdata reloaded into the tx shift register, so the upper logic may change txdata in response to rxready.
- sck falling edge with ss low: tx register shifts left and miso shows the next bit. No shift on the falling edge that follows the 8th bit, because the reload has already occurred.
- ss rising mid-byte: partial byte discarded, no rxready.
- Back-to-back bytes within one ss-low frame are supported indefinitely.

Test Plan:
- Debounce (DB_CYCLES=8): button high 5 cycles then low -> db_state stays 0. Button high 20 cycles -> db_state=1 about 10 cycles after the edge (2 sync + 8).
- Pulse, delay=100, width=100: 1-cycle trigger -> running high 200 cycles; pulse_out high cycles 100..199 after running rises.
- Edge cases: delay=0/width=3 -> pulse_out rises with running, 3 cycles wide. delay=5/width=0 -> running 5 cycles, pulse_out never high.
- Retrigger: trigger held high for 500 cycles with delay=10/width=10 -> back-to-back pulses, each 10 wide; no trigger is accepted while running=1. Assert rst mid-pulse -> both outputs 0 immediately.
- SPI, 6-byte frame 0x10,0x03,0x00,0x00,0x01,0xF4 with txdata=0xA5 then 0x3C: six rxready pulses with matching rxdata; miso returns 0xA5 in byte 0, 0x3C afterwards.
- SPI abort: ss deasserted after 4 bits -> no rxready. The next frame's first byte is received correctly, and miso is Z while ss is high.
